// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin arbiter granting two requesters access to one MDIO controller
module mdio_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic [31:0] frame_0,
    input  logic        req_1,
    input  logic [31:0] frame_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic        done_0,
    output logic        done_1,
    output logic        err,
    output logic [15:0] rdata,
    output logic [31:0] ctl_t_data,
    output logic        ctl_start,
    input  logic        ctl_done,
    input  logic [15:0] ctl_rd_data
);
    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
    state_t state, state_nx;
    logic owner, last_grant, pick, any_req, finish;
    logic [15:0] cnt;
    always_comb begin
        any_req = req_0 || req_1;
        pick = (req_0 && req_1) ? !last_grant : req_1;
        finish = state == WAIT && (ctl_done || cnt == 16'(TIMEOUT));
        state_nx = state == IDLE  ? (any_req ? START : IDLE) :
                   state == START ? WAIT :
                   finish         ? IDLE : WAIT;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= 1'b0;
            last_grant <= 1'b1;
            cnt <= 16'd0;
            ctl_t_data <= 32'd0;
            rdata <= 16'd0;
            done_0 <= 1'b0;
            done_1 <= 1'b0;
            err <= 1'b0;
        end else begin
            done_0 <= finish && !owner;
            done_1 <= finish && owner;
            err <= finish && !ctl_done;
            cnt <= state == WAIT ? cnt + 16'd1 : 16'd0;
            if (state == IDLE && any_req) begin
                owner <= pick;
                last_grant <= pick;
                ctl_t_data <= pick ? frame_1 : frame_0;
            end
            // a completing read wins over a simultaneous timeout
            if (finish && ctl_done && ctl_t_data[29:28] == 2'b10) rdata <= ctl_rd_data;
        end
    end
    assign gnt_0 = state != IDLE && !owner;
    assign gnt_1 = state != IDLE && owner;
    assign ctl_start = state == START;
endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter: transaction-level random and directed checks of mdio_arbiter
module tb_mdio_arbiter;
    localparam int TMO = 8;
    logic clk = 0, reset = 1;
    logic req_0 = 0, req_1 = 0, ctl_done = 0;
    logic [31:0] frame_0 = 0, frame_1 = 0;
    logic [15:0] ctl_rd_data = 0;
    logic gnt_0, gnt_1, done_0, done_1, err, ctl_start;
    logic [15:0] rdata;
    logic [31:0] ctl_t_data;
    int n_chk = 0, n_fail = 0;
    bit last_g = 1;
    logic [15:0] exp_rd = 0;

    mdio_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .frame_0(frame_0), .req_1(req_1), .frame_1(frame_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1), .err(err),
        .rdata(rdata), .ctl_t_data(ctl_t_data), .ctl_start(ctl_start),
        .ctl_done(ctl_done), .ctl_rd_data(ctl_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) chk("excl", {31'd0, gnt_0 & gnt_1}, 32'd0);

    task automatic idle(input int n);
        req_0 = 0;
        req_1 = 0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_gnt", gnt_0 | gnt_1, 0);
            chk("idle_start", ctl_start, 0);
            chk("idle_done", done_0 | done_1 | err, 0);
        end
    endtask

    // dly = WAIT cycle index (0-based) in which ctl_done is high; <0 or >TMO means never
    task automatic txn(input bit r0, input bit r1, input logic [31:0] f0, input logic [31:0] f1,
                       input int dly, input logic [15:0] rd);
        bit w, tmo;
        logic [31:0] ef;
        int last_k;
        req_0 = r0;
        req_1 = r1;
        frame_0 = f0;
        frame_1 = f1;
        w = (r0 && r1) ? !last_g : r1;
        last_g = w;
        ef = w ? f1 : f0;
        tmo = dly < 0 || dly > TMO;
        last_k = tmo ? TMO : dly;
        @(negedge clk);
        chk("start", ctl_start, 1);
        chk("gnt0_start", gnt_0, !w);
        chk("gnt1_start", gnt_1, w);
        chk("tdata_start", ctl_t_data, ef);
        frame_0 = $urandom;
        frame_1 = $urandom;
        ctl_done = 1'($urandom_range(0, 1));
        ctl_rd_data = 16'($urandom);
        if (w) req_1 = 1'($urandom_range(0, 1));
        else req_0 = 1'($urandom_range(0, 1));
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            chk("wait_gnt", w ? gnt_1 : gnt_0, 1);
            chk("wait_start", ctl_start, 0);
            chk("wait_done", done_0 | done_1 | err, 0);
            chk("wait_tdata", ctl_t_data, ef);
            ctl_done = !tmo && k == dly;
            ctl_rd_data = ctl_done ? rd : 16'($urandom);
        end
        @(negedge clk);
        ctl_done = 0;
        chk("done_owner", w ? done_1 : done_0, 1);
        chk("done_other", w ? done_0 : done_1, 0);
        chk("err", err, tmo);
        chk("gnt_release", gnt_0 | gnt_1, 0);
        if (!tmo && ef[29:28] == 2'b10) exp_rd = rd;
        chk("rdata", rdata, exp_rd);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt_0 | gnt_1, 0);
        chk("rst_done", done_0 | done_1 | err, 0);
        chk("rst_start", ctl_start, 0);
        chk("rst_tdata", ctl_t_data, 0);
        chk("rst_rdata", rdata, 0);
        reset = 0;
        idle(1);
        txn(1, 0, 32'h6006_0000, 32'h0, 6, 16'hBEEF);
        idle(2);
        txn(0, 1, 32'h0, 32'h5002_1234, 3, 16'hFFFF);
        idle(1);
        for (int i = 0; i < 4; i++) txn(1, 1, 32'h6001_0000 + i, 32'h5002_0000 + i, 2 + i, 16'(16'hA000 + i));
        idle(1);
        txn(1, 0, 32'h6003_0000, 32'h0, -1, 16'h1111);
        idle(1);
        txn(0, 1, 32'h0, 32'h6004_0000, TMO, 16'h2222);
        idle(1);
        txn(1, 0, 32'h6005_0000, 32'h0, 0, 16'h3333);
        // reset three cycles into WAIT
        req_0 = 1;
        frame_0 = 32'h6007_0000;
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1;
        req_1 = 1;
        ctl_done = 1;
        ctl_rd_data = 16'h5555;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_gnt", gnt_0 | gnt_1, 0);
            chk("mid_rst_done", done_0 | done_1 | err, 0);
            chk("mid_rst_start", ctl_start, 0);
            chk("mid_rst_tdata", ctl_t_data, 0);
            chk("mid_rst_rdata", rdata, 0);
        end
        reset = 0;
        ctl_done = 0;
        exp_rd = 0;
        last_g = 1;
        txn(1, 1, 32'h6008_0000, 32'h6009_0000, 1, 16'h7777);
        for (int i = 0; i < 40; i++) begin
            bit r0, r1;
            int dly;
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            dly = $urandom_range(0, TMO + 3);
            if (dly > TMO + 1) dly = -1;
            txn(r0, r1, {2'b01, 2'($urandom_range(1, 2)), 28'($urandom)},
                {2'b01, 2'($urandom_range(1, 2)), 28'($urandom)}, dly, 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
        end
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
